mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the MIPS datapath (fetch, register file, ALU, data memory) as a multi-cycle machine.
- It replaces the single-cycle opcode decode and adds a memory-ready handshake for slow instruction/data memory.
- It also adds an illegal-opcode flag and a retired-instruction counter.
- It sits between the instruction register opcode field and the datapath muxes, write enables and ALU control.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag, used in BEQ state.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if zero.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  write-back source: 0=ALUOut, 1=MDR.
- PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target.
- ALUOp  output  2  00=add, 01=sub, 10=funct.
- ALUSrcA  output  1  0=PC, 1=rs.
- ALUSrcB  output  2  00=rt, 01=4, 10=sign-ext, 11=sign-ext<<2.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  write register select: 0=rt, 1=rd.
- illegal  output  1  one-cycle pulse on unknown opcode.
- retired  output  CNT_W  instructions completed since reset.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset: while rst=1, all control outputs are 0, illegal=0, retired<=0, state<=FETCH.
  - Outputs are decoded from state, but the rst=1 override has priority.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; that cycle advances to DECODE, otherwise the state holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> FETCH, with illegal=1 for that single cycle and retired unchanged.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD if lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- Any unlisted output is 0 in that state; MemRead and MemWrite are never both 1.
- Retired counter:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BEQ, JUMP or ADDIWB.
  - Wraps modulo 2^CNT_W.
  - Illegal returns to FETCH do not count.
- Latency with mem_ready tied to 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle; request outputs stay stable while waiting.
- mem_ready is ignored in all non-memory states.
- rst mid-instruction:
  - The next cycle is FETCH with retired=0.
  - No partial RegWrite or MemWrite is issued in the reset cycle.
- Unused state encodings 12-15 go to FETCH on the next edge with all outputs 0.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 and opcode=000000 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in RWB; retired=1.
- lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1, IorD=1; then MEMWB with MemtoReg=1; total 8 cycles; retired +1.
- sw (101011), then beq (000100) with zero=1, then j (000010) -> MemWrite pulse in MEMWR; PCWriteCond=1, PCSource=01 in BEQ; PCWrite=1, PCSource=10 in JUMP; retired +3 over 10 cycles.
- opcode=111111 -> DECODE to FETCH with illegal=1 for exactly 1 cycle; retired unchanged; no RegWrite or MemWrite asserted.
- FETCH with mem_ready=0 for 5 cycles -> IRWrite=0 and PCWrite=0 throughout, MemRead=1 held; IRWrite=1 and PCWrite=1 only in the mem_ready=1 cycle.
- Assert rst during MEMWR while mem_ready=0 -> MemWrite=0 in the reset cycle; next state FETCH; retired=0. With CNT_W=4, after 16 addi instructions retired=0 (wrap).

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// waits on a memory-ready handshake, flags unknown opcodes and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire_c;

    // The branch condition is applied in the datapath via PCWriteCond.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = state_q;

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode; reset forces every output low
    always_comb begin
        state_d     = state_q;
        retire_c    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_RTYPE:     state_d = EXEC;
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_BEQ:       state_d = BEQ;
                        OP_ADDI:      state_d = ADDIEX;
                        OP_J:         state_d = JUMP;
                        default: begin
                            illegal = 1'b1;
                            state_d = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) begin
                        state_d = MEMWB;
                    end
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) begin
                        retire_c = 1'b1;
                        state_d  = FETCH;
                    end
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    state_d = RWB;
                end
                RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
                BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    retire_c    = 1'b1;
                    state_d     = FETCH;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
                ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = ADDIWB;
                end
                ADDIWB: begin
                    RegWrite = 1'b1;
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed table-driven bench for mips_multicycle_ctrl, plus a counter-wrap sequence
// on a second instance with a 4-bit retired counter.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic        ALUSrcA, RegWrite, RegDst, illegal;
    logic [31:0] retired;
    logic [3:0]  state;

    logic        b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_MemtoReg;
    logic [1:0]  b_PCSource, b_ALUOp, b_ALUSrcB;
    logic        b_ALUSrcA, b_RegWrite, b_RegDst, b_illegal;
    logic [3:0]  b_retired;
    logic [3:0]  b_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal(illegal), .retired(retired), .state(state)
    );

    mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD), .MemRead(b_MemRead),
        .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .MemtoReg(b_MemtoReg), .PCSource(b_PCSource),
        .ALUOp(b_ALUOp), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .RegWrite(b_RegWrite),
        .RegDst(b_RegDst), .illegal(b_illegal), .retired(b_retired), .state(b_state)
    );

    // Control bundle, MSB first: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
    // PCSource[1:0] ALUOp[1:0] ALUSrcA ALUSrcB[1:0] RegWrite RegDst
    logic [15:0] act_ctl;
    assign act_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

    function automatic logic [15:0] ctl(input logic pw, input logic pwc, input logic iord,
                                        input logic mr, input logic mw, input logic irw,
                                        input logic m2r, input logic [1:0] pcs,
                                        input logic [1:0] aop, input logic asa,
                                        input logic [1:0] asb, input logic rw, input logic rd);
        return {pw, pwc, iord, mr, mw, irw, m2r, pcs, aop, asa, asb, rw, rd};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [15:0] c, input logic ill,
                       input logic [31:0] ret);
        vec_t v;
        v.rst = r; v.op = op; v.zero = z; v.mr = mr;
        v.st = st; v.ctl = c; v.ill = ill; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
        rst = r; opcode = op; zero = z; mem_ready = mr;
    endtask

    logic [15:0] C0, F_WAIT, F_GO, C_DEC, C_MADR, C_MRD, C_MWB, C_MWR;
    logic [15:0] C_EXEC, C_RWB, C_BEQ, C_JMP, C_AEX, C_AWB;

    initial begin
        C0     = '0;
        F_WAIT = ctl(0,0,0,1,0,0,0,2'b00,2'b00,0,2'b01,0,0);
        F_GO   = ctl(1,0,0,1,0,1,0,2'b00,2'b00,0,2'b01,0,0);
        C_DEC  = ctl(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0);
        C_MADR = ctl(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0);
        C_MRD  = ctl(0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0);
        C_MWB  = ctl(0,0,0,0,0,0,1,2'b00,2'b00,0,2'b00,1,0);
        C_MWR  = ctl(0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0);
        C_EXEC = ctl(0,0,0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0);
        C_RWB  = ctl(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1);
        C_BEQ  = ctl(0,1,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0);
        C_JMP  = ctl(1,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0);
        C_AEX  = ctl(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0);
        C_AWB  = ctl(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0);

        // reset held two cycles
        add(1, 6'h00, 0, 1, 4'd0,  C0,     0, 0);
        add(1, 6'h00, 0, 1, 4'd0,  C0,     0, 0);
        // R-type; mem_ready low in DECODE/EXEC must not stall
        add(0, 6'h00, 0, 1, 4'd0,  F_GO,   0, 0);
        add(0, 6'h00, 0, 0, 4'd1,  C_DEC,  0, 0);
        add(0, 6'h00, 0, 0, 4'd6,  C_EXEC, 0, 0);
        add(0, 6'h00, 0, 1, 4'd7,  C_RWB,  0, 0);
        // lw with three wait cycles in MEMRD
        add(0, 6'h00, 0, 1, 4'd0,  F_GO,   0, 1);
        add(0, 6'h23, 0, 1, 4'd1,  C_DEC,  0, 1);
        add(0, 6'h23, 0, 1, 4'd2,  C_MADR, 0, 1);
        add(0, 6'h23, 0, 0, 4'd3,  C_MRD,  0, 1);
        add(0, 6'h23, 0, 0, 4'd3,  C_MRD,  0, 1);
        add(0, 6'h23, 0, 0, 4'd3,  C_MRD,  0, 1);
        add(0, 6'h23, 0, 1, 4'd3,  C_MRD,  0, 1);
        add(0, 6'h23, 0, 1, 4'd4,  C_MWB,  0, 1);
        // sw, beq (zero=1), j
        add(0, 6'h23, 0, 1, 4'd0,  F_GO,   0, 2);
        add(0, 6'h2b, 0, 1, 4'd1,  C_DEC,  0, 2);
        add(0, 6'h2b, 0, 1, 4'd2,  C_MADR, 0, 2);
        add(0, 6'h2b, 0, 1, 4'd5,  C_MWR,  0, 2);
        add(0, 6'h2b, 0, 1, 4'd0,  F_GO,   0, 3);
        add(0, 6'h04, 1, 1, 4'd1,  C_DEC,  0, 3);
        add(0, 6'h04, 1, 1, 4'd8,  C_BEQ,  0, 3);
        add(0, 6'h04, 0, 1, 4'd0,  F_GO,   0, 4);
        add(0, 6'h02, 0, 1, 4'd1,  C_DEC,  0, 4);
        add(0, 6'h02, 0, 1, 4'd9,  C_JMP,  0, 4);
        add(0, 6'h02, 0, 1, 4'd0,  F_GO,   0, 5);
        // illegal opcode, then fetch stalled five cycles
        add(0, 6'h3f, 0, 1, 4'd1,  C_DEC,  1, 5);
        for (int i = 0; i < 5; i++) add(0, 6'h3f, 0, 0, 4'd0, F_WAIT, 0, 5);
        add(0, 6'h3f, 0, 1, 4'd0,  F_GO,   0, 5);
        // addi
        add(0, 6'h08, 0, 1, 4'd1,  C_DEC,  0, 5);
        add(0, 6'h08, 0, 1, 4'd10, C_AEX,  0, 5);
        add(0, 6'h08, 0, 1, 4'd11, C_AWB,  0, 5);
        add(0, 6'h08, 0, 1, 4'd0,  F_GO,   0, 6);
        // sw stalled in MEMWR, reset hits mid-access
        add(0, 6'h2b, 0, 1, 4'd1,  C_DEC,  0, 6);
        add(0, 6'h2b, 0, 1, 4'd2,  C_MADR, 0, 6);
        add(0, 6'h2b, 0, 0, 4'd5,  C_MWR,  0, 6);
        add(1, 6'h2b, 0, 0, 4'd5,  C0,     0, 6);
        add(0, 6'h00, 0, 1, 4'd0,  F_GO,   0, 0);

        // first edge brings state out of X
        drive(1, 6'h00, 0, 1);
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].op, vecs[k].zero, vecs[k].mr);
            @(negedge clk);
            check($sformatf("v%0d state", k),   32'(state),   32'(vecs[k].st));
            check($sformatf("v%0d ctl", k),     32'(act_ctl), 32'(vecs[k].ctl));
            check($sformatf("v%0d illegal", k), 32'(illegal), 32'(vecs[k].ill));
            check($sformatf("v%0d retired", k), retired,      vecs[k].ret);
            check($sformatf("v%0d retired4", k), 32'(b_retired), 32'(vecs[k].ret[3:0]));
            check($sformatf("v%0d memrw", k),   32'(MemRead & MemWrite), 32'd0);
            @(posedge clk); #1;
        end

        // 16 back-to-back addi: 4-bit counter wraps to 0, 32-bit reaches 16
        drive(1, 6'h08, 0, 1);
        @(posedge clk); #1;
        drive(0, 6'h08, 0, 1);
        for (int n = 0; n < 16; n++) begin
            repeat (4) @(posedge clk);
            #1;
            if (n == 14) check("wrap retired4@15", 32'(b_retired), 32'd15);
        end
        @(negedge clk);
        check("wrap state",    32'(state),     32'd0);
        check("wrap retired",  retired,        32'd16);
        check("wrap retired4", 32'(b_retired), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
